// File: rtl/cnn_out_pkg.sv
// Shared widths, FSM state encoding and FIFO entry layout for the CNN output collector.
package cnn_out_pkg;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;
endpackage

// File: rtl/cnn_out_collector_if.sv
// CNN word stream in, framed FIFO stream out, plus status; slave is the collector side.
interface cnn_out_collector_if;
    import cnn_out_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              dout_valid;
    logic              dout_ready;
    logic [DATA_W-1:0] dout_data;
    logic              dout_last;
    logic              overflow;
    logic [CNT_W-1:0]  frame_cnt;

    modport slave (
        input  in_valid, in_data, dout_ready,
        output dout_valid, dout_data, dout_last, overflow, frame_cnt
    );

    modport master (
        output in_valid, in_data, dout_ready,
        input  dout_valid, dout_data, dout_last, overflow, frame_cnt
    );
endinterface

// File: rtl/cnn_out_fifo.sv
// 8-entry FIFO of {last, data}; head is registered storage, push+pop allowed at full.
// A push into a full FIFO without a concurrent pop is silently dropped.
module cnn_out_fifo
    import cnn_out_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  entry_t push_dat_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    // A pop frees the slot the same edge, so a full FIFO can still accept.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + PTR_W'(1) : rd_q;
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_dat_i;
    end
endmodule

// File: rtl/cnn_out_collector.sv
// Frames a CNN valid burst into FIFO entries, tagging the final word via a one-word hold stage.
// Two-edge input-to-output latency; never stalls the CNN, drops words when the FIFO is full.
module cnn_out_collector
    import cnn_out_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    cnn_out_collector_if.slave  bus
);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, full, empty;
    entry_t            push_dat, head;

    cnn_out_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head)
    );

    assign pop            = ~empty & bus.dout_ready;
    assign bus.dout_valid = ~empty;
    assign bus.dout_data  = head.data;
    assign bus.dout_last  = head.last;
    assign bus.overflow   = overflow_q;
    assign bus.frame_cnt  = frame_cnt_q;

    // The held word is only known to be last once in_valid drops behind it.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        push        = 1'b0;
        push_dat    = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = HOLD;
                    hold_d  = bus.in_data;
                end
            end
            HOLD: begin
                push          = 1'b1;
                push_dat.data = hold_q;
                if (bus.in_valid) begin
                    push_dat.last = 1'b0;
                    hold_d        = bus.in_data;
                end else begin
                    push_dat.last = 1'b1;
                    state_d       = IDLE;
                    frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        overflow_d = overflow_q | (push & full & ~pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_cnn_out_collector.sv
// Directed scenarios feed a queue of hand-computed words; a negedge monitor checks every handshake.
module tb_cnn_out_collector;
    import cnn_out_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnn_out_collector_if bus();

    cnn_out_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic l);
        exp_q.push_back('{data: d, last: l});
    endtask

    task automatic apply_reset;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.dout_ready = 1'b0;
        rst            = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 32'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        tick();
    endtask

    task automatic drain(input int n);
        bus.dout_ready = 1'b1;
        repeat (n) tick();
        check("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every accepted output word.
    always @(negedge clk) begin
        if (!rst && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got 0x%08h last=%0b expected no word at %0t",
                         bus.dout_data, bus.dout_last, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout_data", bus.dout_data, e.data);
                check("dout_last", bus.dout_last, 32'(e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.dout_ready = 1'b0;

        // Reset state
        apply_reset();
        check("rst_valid", bus.dout_valid, 0);
        check("rst_data", bus.dout_data, 0);
        check("rst_last", bus.dout_last, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_frame_cnt", bus.frame_cnt, 0);

        // Three-word burst, consumer always ready
        bus.dout_ready = 1'b1;
        expect_word(32'h11, 1'b0);
        expect_word(32'h22, 1'b0);
        expect_word(32'h33, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 32'h11; tick();
        check("lat_e1_valid", bus.dout_valid, 0);
        bus.in_data = 32'h22; tick();
        check("lat_e2_valid", bus.dout_valid, 1);
        check("lat_e2_data", bus.dout_data, 32'h11);
        bus.in_data = 32'h33; tick();
        check("burst_e3_data", bus.dout_data, 32'h22);
        bus.in_valid = 1'b0; bus.in_data = '0; tick();
        check("burst_e4_data", bus.dout_data, 32'h33);
        check("burst_e4_last", bus.dout_last, 1);
        check("burst_frame_cnt", bus.frame_cnt, 1);
        tick();
        check("burst_empty_after", bus.dout_valid, 0);
        drain(3);

        // Single-cycle pulse
        apply_reset();
        bus.dout_ready = 1'b1;
        expect_word(32'hDEADBEEF, 1'b1);
        bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; tick();
        bus.in_valid = 1'b0; bus.in_data = '0; tick();
        check("pulse_data", bus.dout_data, 32'hDEADBEEF);
        check("pulse_last", bus.dout_last, 1);
        check("pulse_frame_cnt", bus.frame_cnt, 1);
        drain(3);

        // Overflow: 10 words, no consumer; 9 and 10 dropped
        apply_reset();
        for (int i = 1; i <= 8; i++) expect_word(32'(i), 1'b0);
        send_frame(10, 32'd1);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_frame_cnt", bus.frame_cnt, 1);
        check("ovf_head", bus.dout_data, 32'd1);
        drain(12);
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_empty_data", bus.dout_data, 0);
        check("ovf_empty_last", bus.dout_last, 0);
        check("ovf_empty_valid", bus.dout_valid, 0);

        // Full FIFO with consumer resuming mid-burst: push+pop at full, nothing lost
        apply_reset();
        for (int i = 0; i < 12; i++) expect_word(32'h100 + 32'(i), (i == 11));
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h100 + 32'(i);
            if (i == 9) bus.dout_ready = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0; bus.in_data = '0; tick();
        check("full_no_overflow", bus.overflow, 0);
        check("full_frame_cnt", bus.frame_cnt, 1);
        drain(14);

        // 256 single-word frames wrap the frame counter
        apply_reset();
        bus.dout_ready = 1'b1;
        for (int f = 0; f < 256; f++) begin
            expect_word(32'h5000 + 32'(f), 1'b1);
            send_frame(1, 32'h5000 + 32'(f));
            if (f == 254) check("wrap_cnt_255", bus.frame_cnt, 255);
        end
        check("wrap_cnt_0", bus.frame_cnt, 0);
        check("wrap_no_overflow", bus.overflow, 0);
        drain(4);

        // Reset mid-frame after the third of five words
        apply_reset();
        bus.dout_ready = 1'b1;
        expect_word(32'hA1, 1'b0);
        expect_word(32'hA2, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA0 + 32'(i);
            tick();
        end
        check("pre_rst_valid", bus.dout_valid, 1);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        exp_q.delete();
        #1;
        check("midrst_valid", bus.dout_valid, 0);
        check("midrst_data", bus.dout_data, 0);
        check("midrst_last", bus.dout_last, 0);
        check("midrst_overflow", bus.overflow, 0);
        check("midrst_frame_cnt", bus.frame_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("post_rst_valid", bus.dout_valid, 0);
        expect_word(32'hA4, 1'b0);
        expect_word(32'hA5, 1'b1);
        send_frame(2, 32'hA4);
        check("resume_frame_cnt", bus.frame_cnt, 1);
        drain(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cnn_out_collector.md
CNN_OUT_COLLECTOR -- requirements
Module: cnn_out_collector

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, driven by the CNN out_valid; high for a contiguous burst = one frame.
REQ-004 SHALL have port in_data, input, 32, driven by the CNN out word; sampled only when in_valid=1.
REQ-005 SHALL have port dout_valid, output, 1, FIFO head word available.
REQ-006 SHALL have port dout_ready, input, 1, consumer accepts head when dout_valid & dout_ready.
REQ-007 SHALL have port dout_data, output, 32, FIFO head word; 0 when FIFO empty.
REQ-008 SHALL have port dout_last, output, 1, head word is final word of its frame; 0 when empty.
REQ-009 SHALL have port overflow, output, 1, sticky flag: a word was dropped.
REQ-010 SHALL have port frame_cnt, output, 8, count of complete frames written into FIFO.

Function
REQ-011 SHALL contain an 8-entry FIFO of {last, data[31:0]} plus a one-word hold register.
REQ-012 SHALL implement FSM with states IDLE (hold empty) and HOLD (hold full).
REQ-013 IDLE & in_valid=1 -> HOLD; in_data captured into hold register; no FIFO push.
REQ-014 HOLD & in_valid=1 -> HOLD; hold word pushed with last=0; new in_data captured.
REQ-015 HOLD & in_valid=0 -> IDLE; hold word pushed with last=1; frame_cnt increments.
REQ-016 IDLE & in_valid=0 -> IDLE; no action.
REQ-017 Latency SHALL be exactly 2 edges: word sampled at edge k is pushed at edge k+1 and is visible on dout from the cycle after edge k+1 if FIFO was empty.
REQ-018 A single-cycle in_valid pulse SHALL yield one FIFO entry with last=1.
REQ-019 Pop SHALL occur at an edge where dout_valid & dout_ready; dout_ready ignored when dout_valid=0.
REQ-020 Simultaneous push and pop SHALL be permitted at any occupancy including full; occupancy unchanged.
REQ-021 Push while full with no pop at the same edge SHALL drop the word, set overflow, leave FIFO unchanged; frame_cnt still increments if the dropped word had last=1.
REQ-022 overflow SHALL stay 1 until reset.
REQ-023 frame_cnt SHALL wrap 255 -> 0.
REQ-024 Read/write pointers SHALL be 3 bits wrapping 7 -> 0; occupancy 4 bits, 0..8.
REQ-025 in_valid has no back-pressure; the block SHALL never stall the CNN.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, empty FIFO, pointers 0, dout_valid=0, dout_data=0, dout_last=0, overflow=0, frame_cnt=0.
REQ-027 Reset asserted mid-frame SHALL discard the hold word and all FIFO contents; no last push occurs.
REQ-028 After rst deasserts, the first in_valid edge SHALL be treated as start of a new frame.

Structure
REQ-029 Package cnn_out_pkg SHALL hold DATA_W=32, DEPTH=8, PTR_W=3, CNT_W=8 and the FSM state enum.
REQ-030 FIFO SHALL be a sub-module cnn_out_fifo (push, pop, full, empty, head); FSM, hold register, counters in cnn_out_collector.

Verification
REQ-031 Burst 0x11,0x22,0x33 with dout_ready=1 -> dout shows 0x11,0x22,0x33 on consecutive cycles starting 2 edges after first sample, last=1 only on 0x33; frame_cnt=1.
REQ-032 Single-cycle pulse 0xDEADBEEF -> one entry, dout_last=1, frame_cnt=1.
REQ-033 dout_ready=0, 10-word burst -> words 1..8 retained, 9 and 10 dropped, overflow=1, frame_cnt=1, drained order 1..8 with last=0 on all.
REQ-034 FIFO full, dout_ready=1 during continued burst -> no drop, overflow stays 0, order preserved.
REQ-035 256 single-word frames -> frame_cnt returns to 0.
REQ-036 rst pulsed mid 5-word burst after word 3 -> all outputs 0 immediately; resumed words form a new frame with correct last.
